int_to_float: RTL and testbench

//  Converts a 32-bit two's-complement integer to an IEEE-754 single-precision float,

---
 rtl/int_to_float_if.sv | 19 +
 rtl/int_to_float.sv | 133 +++++++++++++
 tb/tb_int_to_float.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/int_to_float_if.sv
// rtl/int_to_float_if.sv - stb/ack operand and result channels of the int-to-float converter
interface int_to_float_if;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    modport master (
        output input_a, input_a_stb, output_z_ack,
        input  input_a_ack, output_z, output_z_stb
    );

    modport slave (
        input  input_a, input_a_stb, output_z_ack,
        output input_a_ack, output_z, output_z_stb
    );
endinterface

// File: rtl/int_to_float.sv
// rtl/int_to_float.sv - 32-bit signed int to IEEE-754 single, round to nearest even
module int_to_float (
    input  logic         clk,
    input  logic         rst,
    int_to_float_if.slave bus
);
    typedef enum logic [2:0] {
        get_a, convert_0, convert_1, convert_2, round, pack, put_z
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] a, a_nxt;
    logic [31:0] value, value_nxt;
    logic        z_s, z_s_nxt;
    logic [7:0]  z_e, z_e_nxt;
    logic [23:0] z_m, z_m_nxt;
    logic        guard, guard_nxt;
    logic        round_bit, round_bit_nxt;
    logic        sticky, sticky_nxt;
    logic [31:0] z, z_nxt;
    logic        ack, ack_nxt;
    logic        stb, stb_nxt;
    logic [31:0] z_out, z_out_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= get_a;
            a         <= '0;
            value     <= '0;
            z_s       <= 1'b0;
            z_e       <= '0;
            z_m       <= '0;
            guard     <= 1'b0;
            round_bit <= 1'b0;
            sticky    <= 1'b0;
            z         <= '0;
            ack       <= 1'b0;
            stb       <= 1'b0;
            z_out     <= '0;
        end else begin
            state     <= state_nxt;
            a         <= a_nxt;
            value     <= value_nxt;
            z_s       <= z_s_nxt;
            z_e       <= z_e_nxt;
            z_m       <= z_m_nxt;
            guard     <= guard_nxt;
            round_bit <= round_bit_nxt;
            sticky    <= sticky_nxt;
            z         <= z_nxt;
            ack       <= ack_nxt;
            stb       <= stb_nxt;
            z_out     <= z_out_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        a_nxt         = a;
        value_nxt     = value;
        z_s_nxt       = z_s;
        z_e_nxt       = z_e;
        z_m_nxt       = z_m;
        guard_nxt     = guard;
        round_bit_nxt = round_bit;
        sticky_nxt    = sticky;
        z_nxt         = z;
        ack_nxt       = ack;
        stb_nxt       = stb;
        z_out_nxt     = z_out;
        case (state)
            get_a: begin
                ack_nxt = 1'b1;
                if (ack && bus.input_a_stb) begin
                    a_nxt     = bus.input_a;
                    ack_nxt   = 1'b0;
                    state_nxt = convert_0;
                end
            end
            convert_0: begin
                if (a == 32'd0) begin
                    z_nxt     = 32'h0000_0000;
                    state_nxt = put_z;
                end else begin
                    // -32'h8000_0000 wraps to itself, which is exactly the magnitude 2^31
                    z_s_nxt   = a[31];
                    value_nxt = a[31] ? -a : a;
                    z_e_nxt   = 8'd31;
                    state_nxt = convert_1;
                end
            end
            convert_1: begin
                if (!value[31]) begin
                    value_nxt = value << 1;
                    z_e_nxt   = z_e - 8'd1;
                end else begin
                    state_nxt = convert_2;
                end
            end
            convert_2: begin
                z_m_nxt       = value[31:8];
                guard_nxt     = value[7];
                round_bit_nxt = value[6];
                sticky_nxt    = |value[5:0];
                state_nxt     = round;
            end
            round: begin
                if (guard && (round_bit || sticky || z_m[0])) begin
                    z_m_nxt = z_m + 24'd1;
                    if (z_m == 24'hFF_FFFF) z_e_nxt = z_e + 8'd1;
                end
                state_nxt = pack;
            end
            pack: begin
                z_nxt     = {z_s, z_e + 8'd127, z_m[22:0]};
                state_nxt = put_z;
            end
            put_z: begin
                stb_nxt   = 1'b1;
                z_out_nxt = z;
                if (stb && bus.output_z_ack) begin
                    stb_nxt   = 1'b0;
                    state_nxt = get_a;
                end
            end
            default: state_nxt = get_a;
        endcase
    end

    assign bus.input_a_ack  = ack;
    assign bus.output_z_stb = stb;
    assign bus.output_z     = z_out;
endmodule

// File: tb/tb_int_to_float.sv
// tb/tb_int_to_float.sv - directed and randomized checks of int_to_float against a reference model
module tb_int_to_float;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int_to_float_if bus();

    int_to_float dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint magnitude(input logic [31:0] a);
        longint m;
        m = longint'($signed(a));
        if (m < 0) m = -m;
        return m;
    endfunction

    function automatic int msb_pos(input longint m);
        int p;
        p = 0;
        for (int i = 0; i < 33; i++)
            if (m >= (longint'(1) << i)) p = i;
        return p;
    endfunction

    function automatic logic [31:0] ref_float(input logic [31:0] a);
        longint m, q, rem, half;
        int p, sh;
        if (a == 32'd0) return 32'd0;
        m = magnitude(a);
        p = msb_pos(m);
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                p = p + 1;
            end
        end
        return {a[31], 8'(p + 127), q[22:0]};
    endfunction

    function automatic int ref_latency(input logic [31:0] a);
        if (a == 32'd0) return 2;
        return (31 - msb_pos(magnitude(a))) + 6;
    endfunction

    always @(negedge clk)
        check_eq("ack_stb_exclusive", {31'd0, bus.input_a_ack & bus.output_z_stb}, 32'd0);

    task automatic run_one(input logic [31:0] val, input logic [31:0] exp_z, input int exp_lat,
                           input int pre, input int hold);
        logic [31:0] res;
        int waited, lat;
        @(negedge clk);
        repeat (pre) @(negedge clk);
        bus.input_a     = val;
        bus.input_a_stb = 1'b1;
        waited = 0;
        while (!bus.input_a_ack && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.input_a_ack) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            bus.input_a_stb = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.input_a_stb = 1'b0;
        bus.input_a     = $urandom;
        lat = 0;
        while (!bus.output_z_stb && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("result", bus.output_z, exp_z);
        res = bus.output_z;
        repeat (hold) begin
            @(negedge clk);
            check_eq("hold_stb", {31'd0, bus.output_z_stb}, 32'd1);
            check_eq("hold_z", bus.output_z, res);
            check_eq("hold_ack", {31'd0, bus.input_a_ack}, 32'd0);
        end
        @(negedge clk);
        bus.output_z_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.output_z_ack = 1'b0;
        check_eq("stb_drop", {31'd0, bus.output_z_stb}, 32'd0);
        check_eq("z_keep", bus.output_z, res);
        @(posedge clk);
        #1;
        check_eq("ack_rise", {31'd0, bus.input_a_ack}, 32'd1);
    endtask

    task automatic run_ref(input logic [31:0] val, input int pre, input int hold);
        run_one(val, ref_float(val), ref_latency(val), pre, hold);
    endtask

    initial begin
        logic [31:0] v;
        int r;
        rst              = 1'b1;
        bus.input_a      = '0;
        bus.input_a_stb  = 1'b0;
        bus.output_z_ack = 1'b0;
        #3;
        check_eq("reset_ack", {31'd0, bus.input_a_ack}, 32'd0);
        check_eq("reset_stb", {31'd0, bus.output_z_stb}, 32'd0);
        check_eq("reset_z", bus.output_z, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_one(32'd1,          32'h3F80_0000, 37, 0, 0);
        run_one(32'hFFFF_FFFF,  32'hBF80_0000, 37, 1, 0);
        run_one(32'h8000_0000,  32'hCF00_0000, 6,  0, 2);
        run_one(32'd0,          32'h0000_0000, 2,  2, 0);
        run_one(32'h0100_0001,  32'h4B80_0000, 13, 0, 0);
        run_one(32'h0100_0003,  32'h4B80_0002, 13, 0, 1);
        run_one(32'h7FFF_FFFF,  32'h4F00_0000, 7,  0, 0);
        run_one(32'd123456789,  ref_float(32'd123456789), ref_latency(32'd123456789), 0, 20);

        // abort a conversion of 5 while it is still normalising
        @(negedge clk);
        bus.input_a     = 32'd5;
        bus.input_a_stb = 1'b1;
        @(posedge clk);
        #1;
        bus.input_a_stb = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_ack", {31'd0, bus.input_a_ack}, 32'd0);
        check_eq("async_rst_stb", {31'd0, bus.output_z_stb}, 32'd0);
        check_eq("async_rst_z", bus.output_z, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_one(32'd5, 32'h40A0_0000, 35, 0, 0);

        for (int i = 0; i < 6000; i++) begin
            v = $urandom;
            r = $urandom_range(0, 3);
            if (r == 0) v = v >> $urandom_range(0, 31);
            if (r == 1) v = $signed(v) >>> $urandom_range(0, 31);
            run_ref(v, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                       ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
